// File: rtl/nes_button_debouncer.sv
// Conditions raw NES button-board pins into synchronized, debounced levels,
// with one-cycle press/release strobes and a combined change flag.
module nes_button_debouncer #(
  parameter int NUM_BUTTONS   = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int STABLE_COUNT  = 50000,
  parameter bit ACTIVE_LOW_IN = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_state,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic                   any_change
);

  localparam logic [NUM_BUTTONS-1:0] POL_MASK = ACTIVE_LOW_IN ? '1 : '0;
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX  = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);

  logic [NUM_BUTTONS-1:0] in_n;
  logic [NUM_BUTTONS-1:0] s1;
  logic [NUM_BUTTONS-1:0] s2;
  logic [NUM_BUTTONS-1:0] state_nxt;
  logic [CNT_WIDTH-1:0]   cnt     [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_nxt [NUM_BUTTONS];

  assign in_n = btn_raw ^ POL_MASK;

  // A channel only advances while s2 disagrees with the accepted level;
  // any agreement (including a bounce back) restarts the run from zero.
  always_comb begin
    state_nxt = btn_state;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (s2[i] == btn_state[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        cnt_nxt[i]   = '0;
        state_nxt[i] = s2[i];
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1          <= '0;
      s2          <= '0;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      any_change  <= 1'b0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= in_n;
      s2          <= s1;
      btn_state   <= state_nxt;
      btn_press   <= state_nxt & ~btn_state;
      btn_release <= ~state_nxt & btn_state;
      any_change  <= |(state_nxt ^ btn_state);
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_nes_button_debouncer.sv
// Bench for nes_button_debouncer: two instances (active-low/4-cycle and
// active-high/1-cycle) checked against a sliding-window reference model.
module tb_nes_button_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw0 = 8'hFF;
  logic [7:0] raw1 = 8'h00;
  logic [7:0] st0, pr0, rl0, st1, pr1, rl1;
  logic       ac0, ac1;
  logic       chk_on = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nes_button_debouncer #(.NUM_BUTTONS(8), .CNT_WIDTH(16), .STABLE_COUNT(4),
                         .ACTIVE_LOW_IN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .btn_raw(raw0), .btn_state(st0),
    .btn_press(pr0), .btn_release(rl0), .any_change(ac0));

  nes_button_debouncer #(.NUM_BUTTONS(8), .CNT_WIDTH(16), .STABLE_COUNT(1),
                         .ACTIVE_LOW_IN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .btn_raw(raw1), .btn_state(st1),
    .btn_press(pr1), .btn_release(rl1), .any_change(ac1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the pressed level each edge is recorded in a history;
  // the level reaching s2 at an edge is the one recorded two edges earlier.
  // A channel flips when the last STABLE_COUNT such levels all oppose it.
  logic [7:0] hist [2][0:5];
  logic [7:0] m_state [2];
  logic [7:0] m_press [2];
  logic [7:0] m_rel   [2];
  logic       m_any   [2];
  logic [7:0] pin_v, nxt_v;
  logic       flip;

  function automatic int sc_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 6; k++) hist[d][k] = 8'h00;
        m_state[d] = 8'h00;
        m_press[d] = 8'h00;
        m_rel[d]   = 8'h00;
        m_any[d]   = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        pin_v = (d == 0) ? ~raw0 : raw1;
        for (int k = 5; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = pin_v;
        nxt_v = m_state[d];
        for (int b = 0; b < 8; b++) begin
          flip = 1'b1;
          for (int k = 2; k < sc_of(d) + 2; k++)
            if (hist[d][k][b] == m_state[d][b]) flip = 1'b0;
          if (flip) nxt_v[b] = ~m_state[d][b];
        end
        m_press[d] = nxt_v & ~m_state[d];
        m_rel[d]   = ~nxt_v & m_state[d];
        m_any[d]   = |(nxt_v ^ m_state[d]);
        m_state[d] = nxt_v;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("mdl_state0",   32'(st0), 32'(m_state[0]));
      check("mdl_press0",   32'(pr0), 32'(m_press[0]));
      check("mdl_release0", 32'(rl0), 32'(m_rel[0]));
      check("mdl_any0",     32'(ac0), 32'(m_any[0]));
      check("mdl_state1",   32'(st1), 32'(m_state[1]));
      check("mdl_press1",   32'(pr1), 32'(m_press[1]));
      check("mdl_release1", 32'(rl1), 32'(m_rel[1]));
      check("mdl_any1",     32'(ac1), 32'(m_any[1]));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] st_of(input int d);
    return (d == 0) ? st0 : st1;
  endfunction

  // Counts rising edges until (state & mask) == val; returns at a negedge.
  task automatic wait_vec(input int d, input logic [7:0] mask, input logic [7:0] val,
                          input int exp_n, input string tag);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if ((st_of(d) & mask) == val) break;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #1 reset = 1'b0;
    raw0 = 8'h00;
    raw1 = 8'h00;
    #1 chk_on = 1'b1;
    repeat (3) step();
    check("rst_state", 32'(st0), 32'h00);
    check("rst_press", 32'(pr0), 32'h00);
    check("rst_any",   32'(ac0), 32'h0);

    reset = 1'b1;
    wait_vec(0, 8'hFF, 8'hFF, 6, "rst_rel_latency");
    check("rst_rel_press", 32'(pr0), 32'hFF);
    check("rst_rel_any",   32'(ac0), 32'h1);
    step();
    check("rst_rel_press_once", 32'(pr0), 32'h00);
    check("rst_rel_any_once",   32'(ac0), 32'h0);

    raw0 = 8'hFF;
    wait_vec(0, 8'hFF, 8'h00, 6, "release_all_latency");
    check("release_all_rel", 32'(rl0), 32'hFF);
    step();

    raw0[2] = 1'b0;
    wait_vec(0, 8'h04, 8'h04, 6, "press2_latency");
    check("press2_strobe", 32'(pr0), 32'h04);
    step();
    check("press2_once", 32'(pr0), 32'h00);
    raw0[2] = 1'b1;
    wait_vec(0, 8'h04, 8'h00, 6, "release2_latency");
    check("release2_strobe", 32'(rl0), 32'h04);
    step();
    check("release2_once", 32'(rl0), 32'h00);

    raw0[0] = 1'b0;
    repeat (3) step();
    raw0[0] = 1'b1;
    step();
    raw0[0] = 1'b0;
    check("bounce_quiet", 32'(st0), 32'h00);
    wait_vec(0, 8'h01, 8'h01, 6, "bounce_latency");
    check("bounce_press", 32'(pr0), 32'h01);
    step();
    check("bounce_once", 32'(pr0), 32'h00);
    raw0[0] = 1'b1;
    wait_vec(0, 8'h01, 8'h00, 6, "bounce_release");
    step();

    raw0[5] = 1'b0;
    wait_vec(0, 8'h20, 8'h20, 6, "pre5_latency");
    step();
    raw0[1] = 1'b0;
    raw0[5] = 1'b1;
    wait_vec(0, 8'h22, 8'h02, 6, "simul_latency");
    check("simul_press",   32'(pr0), 32'h02);
    check("simul_release", 32'(rl0), 32'h20);
    check("simul_any",     32'(ac0), 32'h1);
    step();
    check("simul_any_once", 32'(ac0), 32'h0);

    raw0[3] = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_state", 32'(st0), 32'h00);
    check("midrst_press", 32'(pr0), 32'h00);
    check("midrst_any",   32'(ac0), 32'h0);
    step();
    check("midrst_hold_any", 32'(ac0), 32'h0);
    reset = 1'b1;
    wait_vec(0, 8'h0A, 8'h0A, 6, "midrst_latency");
    check("midrst_repress", 32'(pr0), 32'h0A);
    step();

    raw1[7] = 1'b1;
    wait_vec(1, 8'h80, 8'h80, 3, "al0_latency");
    check("al0_press", 32'(pr1), 32'h80);
    step();
    check("al0_once", 32'(pr1), 32'h00);
    raw1[6] = 1'b1;
    step();
    raw1[6] = 1'b0;
    wait_vec(1, 8'h40, 8'h40, 2, "pulse_accept");
    check("pulse_press", 32'(pr1), 32'h40);
    wait_vec(1, 8'h40, 8'h00, 1, "pulse_drop");
    check("pulse_release", 32'(rl1), 32'h40);
    step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) raw0 = raw0 ^ (8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 7) == 0) raw1 = raw1 ^ (8'($urandom) & 8'($urandom));
      reset = ($urandom_range(0, 599) != 0);
      step();
    end
    reset = 1'b1;
    step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
